// File: rtl/timer_cfg_pkg.sv
// Shared definitions for the timer configuration loader: field widths,
// write-select encodings, loader FSM states and the field-update helper.
package timer_cfg_pkg;

    localparam int FIELD_W = 6;
    localparam int CFG_W   = 3 * FIELD_W;

    localparam logic [1:0] SEL_RED    = 2'b00;
    localparam logic [1:0] SEL_YELLOW = 2'b01;
    localparam logic [1:0] SEL_GREEN  = 2'b10;
    localparam logic [1:0] SEL_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        STAGED  = 2'b01,
        PENDING = 2'b10
    } state_e;

    // The word is packed {RED, YELLOW, GREEN}, with red in the top field.
    function automatic logic [CFG_W-1:0] write_field(
        input logic [CFG_W-1:0]   cfg,
        input logic [1:0]         sel,
        input logic [FIELD_W-1:0] data
    );
        logic [CFG_W-1:0] result;
        result = cfg;
        case (sel)
            SEL_RED:    result[3*FIELD_W-1:2*FIELD_W] = data;
            SEL_YELLOW: result[2*FIELD_W-1:FIELD_W]   = data;
            SEL_GREEN:  result[FIELD_W-1:0]           = data;
            default:    result = cfg;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/timer_cfg_loader_tick_prescaler.sv
// Free-running 0..TICK_DIV-1 prescaler; tick is high combinationally during
// the cycle in which the count wraps. pause freezes the count and the tick.
module tick_prescaler #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic pause,
    output logic tick
);

    localparam int              CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!pause) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_cfg_loader.sv
// Shadow/active duration register for the traffic light FSM plus its tick
// strobe. Optional readback ports are enabled by TIMER_CFG_READBACK_EN.
module timer_cfg_loader
    import timer_cfg_pkg::*;
#(
    parameter int TICK_DIV       = 50000000,
    parameter int DEFAULT_RED    = 30,
    parameter int DEFAULT_YELLOW = 5,
    parameter int DEFAULT_GREEN  = 25
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [1:0]         wr_sel,
    input  logic [FIELD_W-1:0] wr_data,
    input  logic               commit,
    input  logic               pause,
`ifdef TIMER_CFG_READBACK_EN
    output logic [CFG_W-1:0]   shadow_config,
    output logic               cfg_pending,
`endif
    output logic [CFG_W-1:0]   timer_config,
    output logic               enable,
    output logic               wr_error,
    output logic               cfg_updated
);

    localparam logic [CFG_W-1:0] DEFAULT_CFG = {FIELD_W'(DEFAULT_RED),
                                                FIELD_W'(DEFAULT_YELLOW),
                                                FIELD_W'(DEFAULT_GREEN)};

    state_e           state_q, state_d;
    logic [CFG_W-1:0] shadow_q, shadow_d;
    logic [CFG_W-1:0] active_q, active_d;
    logic             enable_q;
    logic             wr_error_q;
    logic             cfg_updated_q;

    logic tick;
    logic wr_accept;
    logic wr_good;
    logic wr_bad;
    logic apply;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .pause(pause),
        .tick (tick)
    );

    assign wr_ready = (state_q != PENDING);

    // A write accepted in the same cycle as commit is folded into the commit.
    always_comb begin
        wr_accept = wr_valid && wr_ready;
        wr_good   = wr_accept && (wr_sel != SEL_RSVD) && (wr_data != '0);
        wr_bad    = wr_accept && !wr_good;
        apply     = (state_q == PENDING) && tick;
        shadow_d  = wr_good ? write_field(shadow_q, wr_sel, wr_data) : shadow_q;
        active_d  = apply ? shadow_q : active_q;
        state_d   = state_q;
        unique case (state_q)
            IDLE: begin
                if (wr_good) begin
                    state_d = commit ? PENDING : STAGED;
                end
            end
            STAGED: begin
                if (commit) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            shadow_q      <= DEFAULT_CFG;
            active_q      <= DEFAULT_CFG;
            enable_q      <= 1'b0;
            wr_error_q    <= 1'b0;
            cfg_updated_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            enable_q      <= tick;
            wr_error_q    <= wr_bad;
            cfg_updated_q <= apply;
        end
    end

    assign timer_config = active_q;
    assign enable       = enable_q;
    assign wr_error     = wr_error_q;
    assign cfg_updated  = cfg_updated_q;

`ifdef TIMER_CFG_READBACK_EN
    assign shadow_config = shadow_q;
    assign cfg_pending   = (state_q == PENDING);
`endif

endmodule

// File: tb/tb_timer_cfg_loader.sv
// Directed bench for timer_cfg_loader with TICK_DIV=4: a per-cycle vector
// table followed by a hand-written reset-while-pending sequence.
module tb_timer_cfg_loader;

    localparam int TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [1:0]  wr_sel = 2'b00;
    logic [5:0]  wr_data = 6'd0;
    logic        commit = 1'b0;
    logic        pause = 1'b0;
    logic [17:0] timer_config;
    logic        enable;
    logic        wr_error;
    logic        cfg_updated;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    timer_cfg_loader #(
        .TICK_DIV      (TICK_DIV),
        .DEFAULT_RED   (30),
        .DEFAULT_YELLOW(5),
        .DEFAULT_GREEN (25)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .commit      (commit),
        .pause       (pause),
        .timer_config(timer_config),
        .enable      (enable),
        .wr_error    (wr_error),
        .cfg_updated (cfg_updated)
    );

    typedef struct {
        logic        valid;
        logic [1:0]  sel;
        logic [5:0]  data;
        logic        commit;
        logic        pause;
        logic [17:0] cfg;
        logic        en;
        logic        rdy;
        logic        err;
        logic        upd;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [17:0] mkCfg(input int r, input int y, input int g);
        return {6'(r), 6'(y), 6'(g)};
    endfunction

    task automatic addVec(input logic v, input logic [1:0] s, input logic [5:0] d,
                          input logic c, input logic p, input logic [17:0] cfg,
                          input logic en, input logic rdy, input logic err, input logic upd);
        vec_t t;
        t.valid = v;  t.sel = s;   t.data = d; t.commit = c; t.pause = p;
        t.cfg = cfg;  t.en = en;   t.rdy = rdy; t.err = err; t.upd = upd;
        vecs.push_back(t);
    endtask

    task automatic cmp(input string name, input int step, input logic [17:0] act,
                       input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic checkOutput(input int step, input logic [17:0] cfg, input logic en,
                               input logic rdy, input logic err, input logic upd);
        cmp("timer_config", step, timer_config, cfg);
        cmp("enable", step, 18'(enable), 18'(en));
        cmp("wr_ready", step, 18'(wr_ready), 18'(rdy));
        cmp("wr_error", step, 18'(wr_error), 18'(err));
        cmp("cfg_updated", step, 18'(cfg_updated), 18'(upd));
    endtask

    task automatic applyStimulus(input vec_t t);
        wr_valid = t.valid;
        wr_sel   = t.sel;
        wr_data  = t.data;
        commit   = t.commit;
        pause    = t.pause;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [17:0] c0, c1, c2, c3;
        c0 = mkCfg(30, 5, 25);
        c1 = mkCfg(10, 5, 25);
        c2 = mkCfg(10, 3, 25);
        c3 = mkCfg(7, 3, 25);

        // Steps 1..8: idle after reset, ticks on the 4th and 8th edge.
        for (int i = 1; i <= 8; i++) begin
            addVec(0, 2'b00, 6'd0, 0, 0, c0, (i % 4) == 0, 1, 0, 0);
        end
        // Steps 9..13: write red=10, commit next cycle, apply on tick at 12.
        addVec(1, 2'b00, 6'd10, 0, 0, c0, 0, 1, 0, 0);
        addVec(0, 2'b00, 6'd0,  1, 0, c0, 0, 0, 0, 0);
        addVec(0, 2'b00, 6'd0,  0, 0, c0, 0, 0, 0, 0);
        addVec(0, 2'b00, 6'd0,  0, 0, c1, 1, 1, 0, 1);
        addVec(0, 2'b00, 6'd0,  0, 0, c1, 0, 1, 0, 0);
        // Steps 14..20: rejected writes, then an ignored commit in IDLE.
        addVec(1, 2'b10, 6'd0,  0, 0, c1, 0, 1, 1, 0);
        addVec(1, 2'b11, 6'd7,  0, 0, c1, 0, 1, 1, 0);
        addVec(0, 2'b00, 6'd0,  0, 0, c1, 1, 1, 0, 0);
        addVec(0, 2'b00, 6'd0,  1, 0, c1, 0, 1, 0, 0);
        addVec(0, 2'b00, 6'd0,  0, 0, c1, 0, 1, 0, 0);
        addVec(0, 2'b00, 6'd0,  0, 0, c1, 0, 1, 0, 0);
        addVec(0, 2'b00, 6'd0,  0, 0, c1, 1, 1, 0, 0);
        // Steps 21..25: write+commit together; a write while pending is held off.
        addVec(1, 2'b01, 6'd3,  1, 0, c1, 0, 0, 0, 0);
        addVec(1, 2'b10, 6'd9,  0, 0, c1, 0, 0, 0, 0);
        addVec(0, 2'b00, 6'd0,  0, 0, c1, 0, 0, 0, 0);
        addVec(0, 2'b00, 6'd0,  0, 0, c2, 1, 1, 0, 1);
        addVec(0, 2'b00, 6'd0,  0, 0, c2, 0, 1, 0, 0);
        // Steps 26..38: pending red=7, paused 10 cycles with count held at 2.
        addVec(1, 2'b00, 6'd7,  1, 0, c2, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            addVec(0, 2'b00, 6'd0, 0, 1, c2, 0, 0, 0, 0);
        end
        addVec(0, 2'b00, 6'd0,  0, 0, c2, 0, 0, 0, 0);
        addVec(0, 2'b00, 6'd0,  0, 0, c3, 1, 1, 0, 1);
        // Step 39: stage red=12 with commit, to be discarded by reset.
        addVec(1, 2'b00, 6'd12, 1, 0, c3, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput(0, c0, 0, 1, 0, 0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i + 1, vecs[i].cfg, vecs[i].en, vecs[i].rdy, vecs[i].err, vecs[i].upd);
        end

        wr_valid = 1'b0;
        commit   = 1'b0;
        pause    = 1'b0;
        @(posedge clk);
        #1;
        checkOutput(40, c3, 0, 0, 0, 0);

        reset = 1'b0;
        #1;
        checkOutput(100, c0, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        checkOutput(101, c0, 0, 1, 0, 0);
        reset = 1'b1;

        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            checkOutput(101 + i, c0, (i % 4) == 0, 1, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
